// File: rtl/uart_pkg.sv
// Shared UART types and framing constants for the serial bridge.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through RX FIFO; head is combinational off the read pointer.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Once drained, keep presenting the last head rather than a stale slot.
  assign head    = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (!empty)  last_q   <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// 8N1 UART endpoint: RX deserializer into a FWFT FIFO, TX serializer with ready/write handshake.
// RX byte visible one edge after the stop mid-sample; tx_ready drops the cycle after tx_wren.
module serial_uart_bridge
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rden,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_wren,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // ---------------- RX ----------------
  logic                 rx_meta_q, rxs_q;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_err_wait_q, rx_err_wait_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_overrun_q;
  logic                 rx_push, fifo_full, fifo_empty;

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q + 1'b1;
    rx_idx_d       = rx_idx_q;
    rx_shift_d     = rx_shift_q;
    rx_err_wait_d  = rx_err_wait_q;
    rx_frame_err_d = 1'b0;
    rx_push        = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d      = '0;
        rx_err_wait_d = 1'b0;
        if (rxs_q == START_BIT) begin
          rx_state_d = RX_START;
          rx_idx_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = (rxs_q == START_BIT) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == IDX_LAST) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns to idle.
        if (rx_err_wait_q) begin
          rx_cnt_d = '0;
          if (rxs_q == STOP_BIT) rx_state_d = RX_IDLE;
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxs_q == STOP_BIT) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            rx_err_wait_d  = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q      <= 1'b1;
      rxs_q          <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_err_wait_q  <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      rx_meta_q      <= uart_rxd;
      rxs_q          <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_err_wait_q  <= rx_err_wait_d;
      rx_frame_err_q <= rx_frame_err_d;
      if (rx_push && fifo_full && !(rx_rden && !fifo_empty)) rx_overrun_q <= 1'b1;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (rx_rden),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rx_data)
  );

  assign rx_valid     = ~fifo_empty;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  // ---------------- TX ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_wren) begin
          tx_shift_d = tx_data;
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_idx_d   = tx_idx_q + 1'b1;
          if (tx_idx_q == IDX_LAST) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // The pin is registered from next-state so it lines up with tx_state_q.
    txd_d = STOP_BIT;
    case (tx_state_d)
      TX_START: txd_d = START_BIT;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_ready = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Scoreboard bench for serial_uart_bridge with CLKS_PER_BIT=4, RX_FIFO_DEPTH=4.
module tb_serial_uart_bridge;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  wire        uart_rxd;
  logic       uart_txd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rden = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wren = 1'b0;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic tx_mon_en = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clock = ~clock;

  serial_uart_bridge #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_rden      (rx_rden),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_wren      (tx_wren),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(CPB);
    end
    rxd_drv = stop;
    tick(CPB);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!rx_valid && k < 200) begin
      tick(1);
      k++;
    end
    check(name, rx_valid, 1);
  endtask

  task automatic pop_one();
    wait_valid("rx_wait_valid");
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
  endtask

  // RX monitor: every accepted pop is compared against the scoreboard head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset && rx_valid && rx_rden) begin
        if (exp_rx.size() == 0) begin
          check("rx_unexpected_pop", rx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_rx.pop_front();
          check("rx_data", rx_data, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (rx_frame_err) fe_cnt++;
    end
  end

  // TX monitor: captures all 40 cycles of a frame and compares each against the expected byte.
  initial begin
    logic [9:0] frame;
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (tx_mon_en && reset && uart_txd == 1'b0) begin
        if (exp_tx.size() == 0) begin
          check("tx_unexpected_frame", 0, 1);
          repeat (10 * CPB - 1) @(negedge clock);
        end else begin
          b = exp_tx.pop_front();
          frame = {1'b1, b, 1'b0};
          for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) @(negedge clock);
            check("tx_bit", uart_txd, frame[i / CPB]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b1;
    tick(2);

    // Reset mid-frame: TX sending 0x00 and RX mid start bit.
    tx_data = 8'h00;
    tx_wren = 1'b1;
    rxd_drv = 1'b0;
    tick(1);
    tx_wren = 1'b0;
    tick(6);
    check("tx_low_before_reset", uart_txd, 0);
    #2;
    reset   = 1'b0;
    rxd_drv = 1'b1;
    #1;
    check("rst_txd", uart_txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", rx_frame_err, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    tx_mon_en = 1'b1;
    tick(50);
    check("rx_no_partial", rx_valid, 0);

    // RX single byte with exact latency.
    exp_rx.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    check("rx_valid_before_push", rx_valid, 0);
    tick(1);
    check("rx_valid_after_push", rx_valid, 1);
    check("rx_head_a5", rx_data, 8'hA5);
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
    check("rx_valid_after_pop", rx_valid, 0);

    // One-cycle glitch is a false start.
    rxd_drv = 1'b0;
    tick(1);
    rxd_drv = 1'b1;
    tick(20);
    check("glitch_no_byte", rx_valid, 0);
    check("glitch_no_err", fe_cnt, 0);

    // Framing error: stop bit low.
    send_rx(8'h3C, 1'b0);
    tick(6);
    rxd_drv = 1'b1;
    tick(10);
    check("frame_err_once", fe_cnt, 1);
    check("frame_err_no_byte", rx_valid, 0);

    // Overrun: five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_rx.push_back(8'(i));
      send_rx(8'(i), 1'b1);
    end
    tick(1);
    check("overrun_set", rx_overrun, 1);
    for (int i = 0; i < 4; i++) pop_one();
    tick(1);
    check("overrun_drained", rx_valid, 0);
    check("rx_data_hold_last", rx_data, 8'h04);

    // TX 0x5A; a mid-frame write of 0xFF must be dropped.
    exp_tx.push_back(8'h5A);
    tx_data = 8'h5A;
    tx_wren = 1'b1;
    tick(1);
    tx_wren = 1'b0;
    check("tx_ready_drop", tx_ready, 0);
    tick(10);
    tx_data = 8'hFF;
    tx_wren = 1'b1;
    tick(1);
    tx_wren = 1'b0;
    tick(28);
    check("tx_ready_last_stop", tx_ready, 0);
    tick(1);
    check("tx_ready_back", tx_ready, 1);
    tick(10);

    // Loopback 0xC3 through both paths.
    loop_en = 1'b1;
    exp_tx.push_back(8'hC3);
    exp_rx.push_back(8'hC3);
    tx_data = 8'hC3;
    tx_wren = 1'b1;
    tick(1);
    tx_wren = 1'b0;
    pop_one();
    tick(5);
    loop_en = 1'b0;
    tick(5);

    // Clear the sticky overrun, then push into a full FIFO while popping.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("overrun_cleared", rx_overrun, 0);
    for (int i = 1; i <= 5; i++) exp_rx.push_back(8'(i * 16));
    for (int i = 1; i <= 4; i++) send_rx(8'(i * 16), 1'b1);
    send_rx(8'h50, 1'b1);
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
    check("full_pushpop_no_overrun", rx_overrun, 0);
    check("full_pushpop_valid", rx_valid, 1);
    for (int i = 0; i < 4; i++) pop_one();
    tick(1);
    check("full_pushpop_drained", rx_valid, 0);

    tick(20);
    check("rx_scoreboard_empty", exp_rx.size(), 0);
    check("tx_scoreboard_empty", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Board-side UART endpoint for the processor's serial IO ports.
- Sits between the physical RX/TX pins and the processor's serial_in / serial_valid_in / serial_ready_in / serial_out / serial_rden_out / serial_wren_out, which data_memory uses for memory-mapped serial.
- RX path: deserializes 8N1 frames into a small first-word-fall-through FIFO.
- TX path: serializes one byte at a time, with a ready/write handshake.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- RX_FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- uart_rxd  in  1  serial line from host; idles high; asynchronous to clock.
- uart_txd  out  1  serial line to host; idles high.
- rx_data  out  8  head byte of RX FIFO; drives processor serial_in.
- rx_valid  out  1  RX FIFO not empty; drives processor serial_valid_in.
- rx_rden  in  1  pop RX FIFO head; from processor serial_rden_out.
- tx_ready  out  1  transmitter idle and able to accept a byte; drives processor serial_ready_in.
- tx_data  in  8  byte to send; from processor serial_out.
- tx_wren  in  1  write tx_data; from processor serial_wren_out.
- rx_overrun  out  1  sticky; set when a good frame is dropped because the FIFO is full.
- rx_frame_err  out  1  one-cycle pulse when a frame's stop bit samples low.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Both FSMs go to IDLE and the RX FIFO empties.
  - Output reset values: uart_txd=1, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, rx_frame_err=0.
  - Reset mid-frame abandons the frame; no partial byte is ever delivered.
- RX input conditioning: uart_rxd passes through a 2-flop synchronizer (reset value 1). All RX logic uses the synchronized signal rxs.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: rxs==0 -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 cycles, sample rxs. If 1, it is a false start -> IDLE. If 0 -> DATA, with a full CLKS_PER_BIT count to each later mid-bit sample.
  - DATA: 8 samples, LSB first, shifted into an 8-bit register; after bit 7 -> STOP.
  - STOP: sample rxs at mid-bit.
    - If 1: push the byte. If the FIFO is full and no pop occurs that cycle, drop the byte and set rx_overrun.
    - If 0: pulse rx_frame_err, discard the byte, and wait in STOP until rxs==1 before returning to IDLE.
  - From STOP-sample cycle back to IDLE, the FSM takes one cycle (line already high).
- RX latency: rx_valid rises on the clock edge after the stop-bit mid-sample that pushed into an empty FIFO.
- RX FIFO:
  - First-word-fall-through: rx_data always equals the head entry when rx_valid=1, and holds its last value when empty.
  - rx_rden with rx_valid=1 pops at the clock edge. rx_rden with rx_valid=0 is ignored.
  - Push and pop in the same cycle are both honored, count unchanged, including when full (no overrun).
  - Pointers wrap modulo RX_FIFO_DEPTH. Count width is clog2(RX_FIFO_DEPTH)+1.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx_ready=1, uart_txd=1. tx_wren=1 latches tx_data -> START, and tx_ready drops on the next cycle.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles -> IDLE.
  - tx_wren while tx_ready=0 is ignored; the byte is lost, with no error flag.
  - tx_ready reasserts on the cycle after the last stop-bit cycle. A frame is exactly 10*CLKS_PER_BIT cycles from START entry to IDLE.
- RX and TX are fully independent; simultaneous activity has no interaction.
- Bit counters are sized clog2(CLKS_PER_BIT) and reset to 0 on every state change.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t and tx_state_t enums (IDLE, START, DATA, STOP).
  - Constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module: uart_rx_fifo (params WIDTH=8, DEPTH), first-word-fall-through, with push, pop, full, empty, head ports.
- RX and TX FSMs stay inline in serial_uart_bridge.

Test Plan (CLKS_PER_BIT=4, RX_FIFO_DEPTH=4):
- Reset: hold reset=0 with txd forced mid-frame -> uart_txd=1, tx_ready=1, rx_valid=0 immediately, asynchronously.
- RX byte: drive frame 0xA5 on uart_rxd -> rx_valid=1 and rx_data=0xA5 one edge after the stop mid-sample; rx_rden for 1 cycle -> rx_valid=0.
- RX glitch and framing:
  - uart_rxd low for 1 cycle only -> no byte, no error.
  - Frame 0x3C with stop bit low -> rx_frame_err pulses once, rx_valid stays 0.
- RX overrun: send 0x01..0x05 without rden -> FIFO holds 0x01..0x04, rx_overrun=1. Pop all -> bytes read out in order 01,02,03,04.
- TX: tx_wren with tx_data=0x5A -> tx_ready=0 next cycle; uart_txd shows 0,0,1,0,1,1,0,1,0,1, each bit 4 cycles; tx_ready=1 after 40 cycles. A second tx_wren=0xFF mid-frame is ignored.
- Concurrent: loopback uart_txd to uart_rxd and send 0xC3 -> rx_data=0xC3. An rx_rden and a push in the same cycle at full keep the count at 4 with no overrun.
